// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM state encoding
// and the register-file geometry defaults that the regfile itself also uses.
package regfile_dump_reader_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);
    localparam int DEF_DATA_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a latched register index range through the regfile read port and
// streams {index, data} beats over valid/ready; busy stalls issue meanwhile.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_range_lo,
    input  logic [ADDR_W-1:0] i_range_hi,
    output logic [ADDR_W-1:0] o_rf_addr,
    input  logic [DATA_W-1:0] i_rf_data,
    output logic              o_busy,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_index,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_last,
    output logic              o_done,
    output logic [1:0]        o_dbg_state
);

    // Output handshake: a beat transfers on a rising edge where o_out_valid
    // and i_out_ready are both high; once raised, valid and the beat fields
    // hold unchanged until that transfer, and nothing depends on i_out_ready
    // combinationally.

    state_e              r_state;
    logic [ADDR_W-1:0]   r_cursor;
    logic [ADDR_W-1:0]   r_hi;
    logic [ADDR_W-1:0]   r_out_index;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_busy;
    logic                r_done;
    logic                w_at_hi;

    assign w_at_hi = (r_cursor == r_hi);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cursor    <= '0;
            r_hi        <= '0;
            r_out_index <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cursor <= i_range_lo;
                        r_hi     <= i_range_hi;
                        r_busy   <= 1'b1;
                        // An inverted range completes at once with no beats.
                        if (i_range_lo > i_range_hi) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    r_out_index <= r_cursor;
                    r_out_data  <= i_rf_data;
                    r_out_last  <= w_at_hi;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        // Stopping at hi means the cursor never steps past the top index.
                        if (w_at_hi) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cursor <= r_cursor + 1'b1;
                            r_state  <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rf_addr   = r_cursor;
    assign o_busy      = r_busy;
    assign o_out_valid = r_out_valid;
    assign o_out_index = r_out_index;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_done      = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a regfile model and a beat
// scoreboard fed at dump start and drained as beats are accepted.
module tb_regfile_dump_reader;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] range_lo;
    logic [AW-1:0] range_hi;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_index;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;
    logic [1:0]    dbg_state;

    logic [DW-1:0] rf_mem [32];
    assign rf_data = rf_mem[rf_addr];

    regfile_dump_reader dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_range_lo  (range_lo),
        .i_range_hi  (range_hi),
        .o_rf_addr   (rf_addr),
        .i_rf_data   (rf_data),
        .o_busy      (busy),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_index (out_index),
        .o_out_data  (out_data),
        .o_out_last  (out_last),
        .o_done      (done),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int last_hs_cyc = 0;
    int dump_hs  = 0;
    bit rand_ready = 0;

    // scoreboard: {index, data, last}
    logic [AW+DW:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // monitor: scoreboard drain, stall stability, done timing
    logic          p_valid, p_ready, p_last;
    logic [AW-1:0] p_index;
    logic [DW-1:0] p_data;
    initial begin p_valid = 0; p_ready = 0; p_last = 0; p_index = 0; p_data = 0; end

    always @(negedge clk) begin
        logic [AW+DW:0] e;
        if (!rst_n) begin
            p_valid = 0;
        end else begin
            if (p_valid && !p_ready) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_beat", 64'({out_index, out_data, out_last}),
                    64'({p_index, p_data, p_last}));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(out_index), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 64'({out_index, out_data, out_last}), 64'(e));
                end
                last_hs_cyc = cyc;
                dump_hs++;
            end
            if (done) begin
                done_cnt++;
                if (dump_hs > 0) chk("done_after_last_hs", 64'(cyc), 64'(last_hs_cyc + 1));
            end
            p_valid = out_valid;
            p_ready = out_ready;
            p_index = out_index;
            p_data  = out_data;
            p_last  = out_last;
        end
    end

    // driver tasks
    task automatic start_dump(input logic [AW-1:0] lo, input logic [AW-1:0] hi);
        if (lo <= hi)
            for (int i = int'(lo); i <= int'(hi); i++)
                exp_q.push_back({AW'(i), rf_mem[i], (i == int'(hi))});
        dump_hs = 0;
        @(posedge clk); #1;
        start = 1'b1; range_lo = lo; range_hi = hi;
        @(posedge clk); #1;
        start = 1'b0;
        range_lo = AW'($urandom_range(0, 31));
        range_hi = AW'($urandom_range(0, 31));
    endtask

    task automatic wait_done(input int budget, output int cycles, output int busy_cycles,
                             output int valid_cycles);
        cycles = 0; busy_cycles = 0; valid_cycles = 0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (busy) busy_cycles++;
            if (out_valid) valid_cycles++;
            if (done) break;
        end
        if (!done) chk("done_timeout", 64'(cycles), 64'(budget + 1));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_last"},  64'(out_last), 64'd0);
        chk({tag, "_done"},  64'(done), 64'd0);
        chk({tag, "_index"}, 64'(out_index), 64'd0);
        chk({tag, "_data"},  64'(out_data), 64'd0);
        chk({tag, "_rfaddr"}, 64'(rf_addr), 64'd0);
        chk({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    initial begin
        int c, b, v, dc;
        for (int i = 0; i < 32; i++) rf_mem[i] = DW'(i * 3);
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; range_lo = '0; range_hi = '0;

        // reset state
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // full dump 0..31
        start_dump(5'd0, 5'd31);
        wait_done(200, c, b, v);
        chk("full_cycles", 64'(c), 64'd65);
        chk("full_busy", 64'(b), 64'd65);
        chk("full_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("full_done_pulse", 64'(done), 64'd0);
        chk("full_busy_idle", 64'(busy), 64'd0);

        // partial range 10..12
        rf_mem[10] = 32'd5; rf_mem[11] = 32'd7; rf_mem[12] = 32'd6;
        start_dump(5'd10, 5'd12);
        wait_done(50, c, b, v);
        chk("partial_cycles", 64'(c), 64'd7);
        chk("partial_drained", 64'(exp_q.size()), 64'd0);

        // backpressure on 12..12
        out_ready = 1'b0;
        start_dump(5'd12, 5'd12);
        c = 0;
        while (!out_valid && c < 10) begin @(negedge clk); c++; end
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        chk("bp_latency", 64'(c), 64'd2);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_hold", 64'({out_valid, out_index, out_data}), 64'({1'b1, 5'd12, 32'd6}));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(5, c, b, v);
        chk("bp_done_cycles", 64'(c), 64'd2);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // empty range
        start_dump(5'd20, 5'd4);
        wait_done(5, c, b, v);
        chk("empty_cycles", 64'(c), 64'd1);
        chk("empty_busy", 64'(b), 64'd1);
        chk("empty_valid", 64'(v), 64'd0);
        @(negedge clk);
        chk("empty_busy_after", 64'(busy), 64'd0);

        // ignored start during SEND, then reset abort
        start_dump(5'd0, 5'd31);
        repeat (9) @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1; range_lo = 5'd0; range_hi = 5'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_mid_busy", 64'(busy), 64'd1);
        dc = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'(dc));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // fresh dump after reset with random backpressure
        rand_ready = 1;
        start_dump(5'd10, 5'd12);
        wait_done(200, c, b, v);
        chk("post_reset_drained", 64'(exp_q.size()), 64'd0);
        rand_ready = 0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug/trace reader for the processor's register file: on a start pulse it walks a latched index range, reads each architectural register through the regfile read port, and streams `{index, data}` beats out over a valid/ready interface. It sits beside the decode-stage read port and asserts `busy` so the core control stalls instruction issue while the dump owns the port. It is the read-side counterpart of writeback-driven regfile writes and is used by the debug unit and by end-of-test state checking.

## Interface
- `NUM_REGS`, 32, number of architectural registers; index range is 0..NUM_REGS-1
- `ADDR_W`, 5, register index width; `ADDR_W` = clog2(NUM_REGS)
- `DATA_W`, 32, register data width
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset)
- `start`  in  1  request a dump; sampled only in IDLE
- `range_lo`  in  ADDR_W  first index to read; latched when `start` is accepted
- `range_hi`  in  ADDR_W  last index to read, inclusive; latched with `range_lo`
- `rf_addr`  out  ADDR_W  regfile read index
- `rf_data`  in  DATA_W  regfile read data; combinational, valid in the same cycle as `rf_addr`
- `busy`  out  1  high from the cycle after `start` is accepted until return to IDLE
- `out_valid`  out  1  beat available
- `out_ready`  in  1  consumer accepts beat
- `out_index`  out  ADDR_W  register index of current beat
- `out_data`  out  DATA_W  register contents of current beat
- `out_last`  out  1  current beat is index `range_hi`
- `done`  out  1  one-cycle pulse when the dump completes or is rejected

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: `start`=1 → latch `range_lo`/`range_hi` and set cursor = `range_lo`. If `range_lo` > `range_hi`, go to DONE with no beats; otherwise go to READ.
- READ (one cycle): drive `rf_addr` = cursor, register `rf_data` into `out_data` and cursor into `out_index`, then go to SEND.
- SEND: hold `out_valid`=1 with stable `out_index`/`out_data`/`out_last` until `out_valid && out_ready`. On handshake:
  - If cursor == latched hi → DONE.
  - Otherwise cursor += 1 → READ.
- DONE: `done`=1 for exactly one cycle → IDLE.
- `out_last` = (cursor == latched hi) while in SEND.
- `start` outside IDLE is ignored and is not queued.
- Changes on `range_lo`/`range_hi` after acceptance have no effect.
- Cursor never wraps: the last index is NUM_REGS-1 at most. `range_hi` = NUM_REGS-1 terminates without incrementing past the top.
- Index 0 is read like any other register; the value is whatever the regfile returns (expected 0).
- `rf_addr` outside READ is driven with the cursor. It is don't-care to consumers, but must be a stable registered value (no X).

## Timing
- Reset values: state = IDLE, `busy`=0, `out_valid`=0, `out_last`=0, `done`=0, `out_index`=0, `out_data`=0, `rf_addr`=0, cursor = 0.
- Reset asserted mid-dump aborts immediately: all outputs return to reset values asynchronously, no `done` pulse, and the partially sent beat is dropped.
- Start latency: `start` high in cycle 0 → READ in cycle 1 → `out_valid` high in cycle 2.
- Throughput: one beat per 2 cycles when `out_ready` is held high. A full 32-register dump is 64 cycles from READ to the last handshake, then 1 DONE cycle.
- Backpressure: `out_ready` low stalls SEND indefinitely. The output is not permitted to change or drop valid while stalled.
- `busy` is high in READ, SEND and DONE, and low in IDLE.
- Empty range: `start` in cycle 0 → `done` in cycle 1, `busy` high only in cycle 1, no `out_valid`.
- All outputs are registered; there is no combinational path from `out_ready` to `out_valid` or to the data outputs.

## Structure
- The shared package holds:
  - the state enum (IDLE, READ, SEND, DONE);
  - the NUM_REGS/ADDR_W/DATA_W defaults, which are shared with the regfile.
- Single module; no sub-module is warranted. The FSM, cursor and output register fit in one block.

## Test plan
- Full dump: regfile preloaded with xN = N*3, `range_lo`=0, `range_hi`=31, `out_ready`=1 → 32 beats with index 0..31 and data 0,3,…,93, `out_last` only on index 31, `done` 1 cycle after the last handshake.
- Partial range: preload x10=5, x11=7, x12=6; range 10..12 → exactly 3 beats (10,5), (11,7), (12,6); `out_last` on 12.
- Backpressure: range 12..12, `out_ready` low for 7 cycles → `out_valid`/`out_index`=12/`out_data`=6 held stable for all 7 cycles; the handshake occurs on the first ready cycle, then `done`.
- Empty range: lo=20, hi=4 → no `out_valid`, `done` in the cycle after `start`, `busy` high for exactly 1 cycle.
- Ignored start and reset abort: pulse `start` with a new range during SEND → no effect on the current dump. Assert `rst`=0 mid-dump → outputs go to reset values at once with no `done`. A new dump after reset runs from its own `range_lo`.
